count_event_monitor: RTL and testbench

- Sits directly downstream of the up/down counter.
- Samples the counter's `count` and `mode` every clock and detects wrap-around: overflow (MAX->0) and underflow (0->MAX).
- Also detects programmable match hits, direction changes and stalls. Keeps saturating wrap tallies and a sticky, maskable interrupt flag with a clear input.
- Provides the status/event layer the counter lacks.

---
 rtl/count_mon_pkg.sv | 14 +
 rtl/count_event_monitor_sat_counter.sv | 26 ++
 rtl/count_event_monitor.sv | 130 +++++++++++++
 tb/tb_count_event_monitor.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and constants for count_event_monitor.
package count_mon_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int IRQ_OVF   = 0;
  localparam int IRQ_UNF   = 1;
  localparam int IRQ_MATCH = 2;
  localparam int IRQ_STALL = 3;

endpackage

// File: rtl/count_event_monitor_sat_counter.sv
// Saturating up-counter with clear priority; used for wrap tallies and the stall run length.
module sat_counter #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  // Count up to LIMIT and hold there; clr beats inc.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != LIMIT)) begin
      value <= value + WIDTH'(1);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// Wrap/match/direction/stall event monitor for an up/down counter.
// Optional min/max tracking is enabled by defining COUNT_MONITOR_MINMAX_EN.
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int size      = 4,
  parameter int WRAP_W    = 8,
  parameter int STALL_LIM = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [size-1:0]   count,
  input  logic              mode,
  input  logic [size-1:0]   match_val,
  input  logic [3:0]        irq_mask,
  input  logic              clear,
  output logic              ovf_pulse,
  output logic              unf_pulse,
  output logic              match_pulse,
  output logic              dir_change,
  output logic              stall,
  output logic [WRAP_W-1:0] ovf_cnt,
  output logic [WRAP_W-1:0] unf_cnt,
  output logic              irq_flag
`ifdef COUNT_MONITOR_MINMAX_EN
  ,
  output logic [size-1:0]   min_seen,
  output logic [size-1:0]   max_seen
`endif
);

  localparam logic [size-1:0] MAX       = {size{1'b1}};
  localparam int              STALL_W   = $clog2(STALL_LIM + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIM);
  localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_LIM - 1);

  state_t             state;
  logic [size-1:0]    prev_count;
  logic               prev_mode;
  logic [STALL_W-1:0] stall_cnt;
  logic               tracking;
  logic               same;
  logic               dir_ev;
  logic [3:0]         ev;

  // Event detection against the previous sample; the stall event is the cycle stall_cnt reaches the limit.
  always_comb begin
    tracking = (state == TRACK);
    same     = (count == prev_count);
    ev       = 4'b0000;
    dir_ev   = 1'b0;
    if (tracking) begin
      ev[IRQ_OVF]   = (prev_count == MAX) && (count == '0);
      ev[IRQ_UNF]   = (prev_count == '0) && (count == MAX);
      ev[IRQ_MATCH] = (count == match_val) && !same;
      ev[IRQ_STALL] = same && (stall_cnt == STALL_PRE);
      dir_ev        = (mode != prev_mode);
    end else begin
      ev     = 4'b0000;
      dir_ev = 1'b0;
    end
  end

  // Sequencing, sample history, registered pulses and the sticky irq (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      prev_count  <= '0;
      prev_mode   <= 1'b0;
      ovf_pulse   <= 1'b0;
      unf_pulse   <= 1'b0;
      match_pulse <= 1'b0;
      dir_change  <= 1'b0;
      irq_flag    <= 1'b0;
    end else begin
      state       <= TRACK;
      prev_count  <= count;
      prev_mode   <= mode;
      ovf_pulse   <= ev[IRQ_OVF];
      unf_pulse   <= ev[IRQ_UNF];
      match_pulse <= ev[IRQ_MATCH];
      dir_change  <= dir_ev;
      irq_flag    <= (|(ev & irq_mask)) | (irq_flag & ~clear);
    end
  end

  sat_counter #(.WIDTH(WRAP_W)) u_ovf_tally (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (ev[IRQ_OVF]),
    .value (ovf_cnt)
  );

  sat_counter #(.WIDTH(WRAP_W)) u_unf_tally (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (ev[IRQ_UNF]),
    .value (unf_cnt)
  );

  // Run length of unchanged samples; restarts on any change and while in INIT.
  sat_counter #(.WIDTH(STALL_W), .LIMIT(STALL_MAX)) u_stall_run (
    .clk   (clk),
    .reset (reset),
    .clr   (~(tracking & same)),
    .inc   (tracking & same),
    .value (stall_cnt)
  );

  assign stall = (stall_cnt == STALL_MAX);

`ifdef COUNT_MONITOR_MINMAX_EN
  // Running extremes; reloaded from the live count on entry and on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_seen <= '0;
      max_seen <= '0;
    end else if (!tracking || clear) begin
      min_seen <= count;
      max_seen <= count;
    end else begin
      min_seen <= (count < min_seen) ? count : min_seen;
      max_seen <= (count > max_seen) ? count : max_seen;
    end
  end
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor (size=4, WRAP_W=8, STALL_LIM=16).
module tb_count_event_monitor;

  localparam int MAXV = 15;
  localparam int LIM  = 16;
  localparam int TMAX = 255;

  logic       clk = 1'b0;
  logic       reset, mode, clear;
  logic [3:0] count, match_val, irq_mask;
  logic       ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag;
  logic [7:0] ovf_cnt, unf_cnt;
`ifdef COUNT_MONITOR_MINMAX_EN
  logic [3:0] min_seen, max_seen;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (integer/boolean view of the behaviour)
  bit m_init, m_prev_mode;
  int m_prev, m_run, m_ovf_cnt, m_unf_cnt;
  bit m_ovf, m_unf, m_match, m_dir, m_stall, m_irq;
  int m_min, m_max;

  always #5 clk = ~clk;

  count_event_monitor #(.size(4), .WRAP_W(8), .STALL_LIM(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .mode        (mode),
    .match_val   (match_val),
    .irq_mask    (irq_mask),
    .clear       (clear),
    .ovf_pulse   (ovf_pulse),
    .unf_pulse   (unf_pulse),
    .match_pulse (match_pulse),
    .dir_change  (dir_change),
    .stall       (stall),
    .ovf_cnt     (ovf_cnt),
    .unf_cnt     (unf_cnt),
    .irq_flag    (irq_flag)
`ifdef COUNT_MONITOR_MINMAX_EN
    ,
    .min_seen    (min_seen),
    .max_seen    (max_seen)
`endif
  );

  task automatic cycle(input int c, input bit md);
    int  cv;
    bit  e_ovf, e_unf, e_match, e_dir, e_stall;
    count = 4'(c);
    mode  = md;
    @(posedge clk);
    cv = int'(count);
    e_ovf = 0; e_unf = 0; e_match = 0; e_dir = 0; e_stall = 0;
    if (reset) begin
      m_init = 1; m_prev = 0; m_prev_mode = 0; m_run = 0;
      m_ovf_cnt = 0; m_unf_cnt = 0; m_irq = 0; m_stall = 0;
      m_min = 0; m_max = 0;
    end else begin
      if (!m_init) begin
        e_ovf   = (m_prev == MAXV) && (cv == 0);
        e_unf   = (m_prev == 0) && (cv == MAXV);
        e_match = (cv == int'(match_val)) && (cv != m_prev);
        e_dir   = (mode != m_prev_mode);
        m_run   = (cv == m_prev) ? ((m_run < LIM) ? m_run + 1 : LIM) : 0;
        if (clear) begin m_min = cv; m_max = cv; end
        else begin
          if (cv < m_min) m_min = cv;
          if (cv > m_max) m_max = cv;
        end
      end else begin
        m_run = 0; m_min = cv; m_max = cv;
      end
      e_stall = (m_run == LIM) && !m_stall;
      m_stall = (m_run == LIM);
      if (clear) begin
        m_ovf_cnt = 0; m_unf_cnt = 0;
      end else begin
        if (e_ovf && m_ovf_cnt < TMAX) m_ovf_cnt++;
        if (e_unf && m_unf_cnt < TMAX) m_unf_cnt++;
      end
      m_irq = (e_ovf && irq_mask[0]) || (e_unf && irq_mask[1]) ||
              (e_match && irq_mask[2]) || (e_stall && irq_mask[3]) || (m_irq && !clear);
      m_prev = cv; m_prev_mode = mode; m_init = 0;
    end
    m_ovf = e_ovf; m_unf = e_unf; m_match = e_match; m_dir = e_dir;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; irq_mask = 4'b0001; match_val = 4'd10;
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    checks++;
    if ({ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag, ovf_cnt, unf_cnt} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want all zero",
               {ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag, ovf_cnt, unf_cnt});
    end
    reset = 1'b0;
  endtask

  task automatic test_overflow();
    cycle(13, 1'b1);
    checks++;
    if ({ovf_pulse, unf_pulse, match_pulse, dir_change} !== 4'b0000) begin
      errors++; $display("FAIL first_sample_pulses got %b want 0000", {ovf_pulse, unf_pulse, match_pulse, dir_change});
    end
    cycle(14, 1'b1);
    cycle(15, 1'b1);
    checks++;
    if (ovf_pulse !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf_pulse); end
    cycle(0, 1'b1);
    checks++;
    if (ovf_pulse !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", ovf_pulse); end
    checks++;
    if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt got %0d want 1", ovf_cnt); end
    checks++;
    if (irq_flag !== 1'b1) begin errors++; $display("FAIL ovf_irq got %b want 1", irq_flag); end
    cycle(1, 1'b1);
    checks++;
    if (ovf_pulse !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b want 0", ovf_pulse); end
  endtask

  task automatic test_underflow();
    int n_unf = 0, n_dir = 0;
    int seq [5] = '{2, 1, 0, 15, 14};
    irq_mask = 4'b0000;
    foreach (seq[i]) begin
      cycle(seq[i], 1'b0);
      n_unf += int'(unf_pulse);
      n_dir += int'(dir_change);
    end
    checks++;
    if (n_unf != 1) begin errors++; $display("FAIL unf_pulses got %0d want 1", n_unf); end
    checks++;
    if (n_dir != 1) begin errors++; $display("FAIL dir_pulses got %0d want 1", n_dir); end
    checks++;
    if (unf_cnt !== 8'd1) begin errors++; $display("FAIL unf_cnt got %0d want 1", unf_cnt); end
  endtask

  task automatic test_match();
    int n_match = 0;
    int seq [5] = '{4, 5, 5, 5, 6};
    clear = 1'b1;
    cycle(3, 1'b0);
    clear = 1'b0;
    checks++;
    if (irq_flag !== 1'b0) begin errors++; $display("FAIL clear_irq got %b want 0", irq_flag); end
    irq_mask = 4'b1011; match_val = 4'd5;
    foreach (seq[i]) begin
      cycle(seq[i], 1'b0);
      n_match += int'(match_pulse);
    end
    checks++;
    if (n_match != 1) begin errors++; $display("FAIL match_pulses got %0d want 1", n_match); end
    checks++;
    if (irq_flag !== 1'b0) begin errors++; $display("FAIL match_masked_irq got %b want 0", irq_flag); end
  endtask

  task automatic test_stall();
    int rise_at = -1;
    irq_mask = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      cycle(7, 1'b0);
      if (stall === 1'b1 && rise_at < 0) rise_at = i;
    end
    checks++;
    if (rise_at != 16) begin errors++; $display("FAIL stall_rise got %0d want 16", rise_at); end
    checks++;
    if (irq_flag !== 1'b1) begin errors++; $display("FAIL stall_irq got %b want 1", irq_flag); end
    cycle(8, 1'b0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_drop got %b want 0", stall); end
  endtask

  task automatic test_clear_priority();
    irq_mask = 4'b0001;
    cycle(14, 1'b0);
    cycle(15, 1'b0);
    clear = 1'b1;
    cycle(0, 1'b0);
    checks++;
    if (irq_flag !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b want 1", irq_flag); end
    checks++;
    if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL clear_beats_tally got %0d want 0", ovf_cnt); end
    cycle(1, 1'b0);
    clear = 1'b0;
    checks++;
    if (irq_flag !== 1'b0) begin errors++; $display("FAIL clear_alone got %b want 0", irq_flag); end
  endtask

  task automatic test_saturation();
    irq_mask = 4'b0000;
    for (int i = 0; i < 260; i++) begin
      cycle(15, 1'b0);
      cycle(0, 1'b0);
    end
    checks++;
    if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_saturate got %0d want 255", ovf_cnt); end
    checks++;
    if (unf_cnt !== 8'd255) begin errors++; $display("FAIL unf_saturate got %0d want 255", unf_cnt); end
  endtask

  task automatic test_midreset();
    cycle(15, 1'b1);
    reset = 1'b1;
    cycle(15, 1'b1);
    checks++;
    if ({ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag, ovf_cnt, unf_cnt} !== 22'd0) begin
      errors++; $display("FAIL midreset_outputs got %b want all zero",
                         {ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag, ovf_cnt, unf_cnt});
    end
    reset = 1'b0;
    cycle(0, 1'b0);
    checks++;
    if ({ovf_pulse, dir_change} !== 2'b00) begin
      errors++; $display("FAIL midreset_init got %b want 00", {ovf_pulse, dir_change});
    end
    cycle(1, 1'b0);
    checks++;
    if ({ovf_pulse, unf_pulse, dir_change} !== 3'b000) begin
      errors++; $display("FAIL midreset_track got %b want 000", {ovf_pulse, unf_pulse, dir_change});
    end
  endtask

`ifdef COUNT_MONITOR_MINMAX_EN
  task automatic test_minmax();
    reset = 1'b1;
    cycle(0, 1'b0);
    reset = 1'b0;
    cycle(3, 1'b0);
    cycle(9, 1'b0);
    cycle(1, 1'b0);
    checks++;
    if (min_seen !== 4'd1) begin errors++; $display("FAIL min_seen got %0d want 1", min_seen); end
    checks++;
    if (max_seen !== 4'd9) begin errors++; $display("FAIL max_seen got %0d want 9", max_seen); end
  endtask
`endif

  task automatic test_random();
    int c = int'(count);
    bit md = mode;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) c = (c + 1) % 16;
      else if (r <= 6) c = (c + 15) % 16;
      else if (r == 9) c = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) md = ~md;
      irq_mask  = 4'($urandom_range(0, 15));
      match_val = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      cycle(c, md);
      checks++;
      if ({ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag} !==
          {m_ovf, m_unf, m_match, m_dir, m_stall, m_irq}) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got %b want %b", i,
                 {ovf_pulse, unf_pulse, match_pulse, dir_change, stall, irq_flag},
                 {m_ovf, m_unf, m_match, m_dir, m_stall, m_irq});
      end
      checks++;
      if (ovf_cnt !== 8'(m_ovf_cnt) || unf_cnt !== 8'(m_unf_cnt)) begin
        errors++;
        $display("FAIL rand_tallies cyc %0d got %0d/%0d want %0d/%0d", i, ovf_cnt, unf_cnt, m_ovf_cnt, m_unf_cnt);
      end
`ifdef COUNT_MONITOR_MINMAX_EN
      checks++;
      if (min_seen !== 4'(m_min) || max_seen !== 4'(m_max)) begin
        errors++;
        $display("FAIL rand_minmax cyc %0d got %0d/%0d want %0d/%0d", i, min_seen, max_seen, m_min, m_max);
      end
`endif
    end
    reset = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    count = 4'd0; mode = 1'b0; clear = 1'b0; reset = 1'b1;
    match_val = 4'd10; irq_mask = 4'b0000;
    test_reset();
    test_overflow();
    test_underflow();
    test_match();
    test_stall();
    test_clear_priority();
    test_saturation();
    test_midreset();
`ifdef COUNT_MONITOR_MINMAX_EN
    test_minmax();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
